// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a shift-add multiply, with a valid/ready result handshake.
// state | meaning: IDLE accept operands | MUL shift-add in progress | DONE result held for the sink
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 cout,
    output logic                 v,
    output logic                 zero,
    output logic                 busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc, mcand, acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 last_step;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   res;
    logic                 res_c, res_v;

    assign last_step = (cnt == CNT_W'(WIDTH-1));
    assign acc_nxt   = acc + (mplier[0] ? (mcand << cnt) : '0);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        sum   = '0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                res[WIDTH-1:0] = {a[WIDTH-2:0], 1'b0};
                res_c          = a[WIDTH-1];
            end
            OP_XNOR: res[WIDTH-1:0] = a ~^ b;
            OP_CMP:  res[2:0] = {a > b, a == b, a < b};
            OP_SHR: begin
                res[WIDTH-1:0] = {1'b0, a[WIDTH-1:1]};
                res_c          = a[0];
            end
            OP_PASS: res[WIDTH-1:0] = a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (op == OP_MUL) ? MUL : DONE;
            end
            MUL: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only change on a write; they hold through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= '0;
            cout   <= 1'b0;
            v      <= 1'b0;
            zero   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            out  <= res;
                            cout <= res_c;
                            v    <= res_v;
                            zero <= (res == '0);
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        out  <= acc_nxt;
                        cout <= 1'b0;
                        v    <= 1'b0;
                        zero <= (acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
